// File: rtl/fu_config_seq.sv
// fu_config_seq: replays a small stored program of configuration contexts
// onto the FU cluster's config_all bus. Each context has its own hold count,
// and the whole program repeats for a programmed number of iterations.
module fu_config_seq #(
  parameter int CONFIG_ALL = 64,
  parameter int NUM_CTX    = 8,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       cfg_wr_valid,
  output logic                       cfg_wr_ready,
  input  logic [$clog2(NUM_CTX)-1:0] cfg_wr_addr,
  input  logic [CONFIG_ALL-1:0]      cfg_wr_data,
  input  logic [CNT_WIDTH-1:0]       cfg_wr_hold,
  input  logic                       cfg_wr_last,
  input  logic                       start,
  input  logic [CNT_WIDTH-1:0]       loop_count,
  input  logic                       stop,
  output logic [CONFIG_ALL-1:0]      config_all,
  output logic                       cfg_active,
  output logic                       busy,
  output logic                       done,
  output logic [$clog2(NUM_CTX)-1:0] ctx_idx
);

  localparam int IDX_W = $clog2(NUM_CTX);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CTX - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } state_t;

  state_t                r_state;
  state_t                w_stateNext;

  logic [CONFIG_ALL-1:0] r_ctxData [NUM_CTX];
  logic [CNT_WIDTH-1:0]  r_ctxHold [NUM_CTX];
  logic [NUM_CTX-1:0]    r_ctxLast;

  logic [CNT_WIDTH-1:0]  r_holdCnt;
  logic [CNT_WIDTH-1:0]  r_iterCnt;
  logic                  r_infinite;
  logic [IDX_W-1:0]      r_ctxIdx;
  logic [CONFIG_ALL-1:0] r_configAll;
  logic                  r_cfgActive;
  logic                  r_busy;
  logic                  r_done;

  logic [CNT_WIDTH-1:0]  w_holdNext;
  logic [CNT_WIDTH-1:0]  w_iterNext;
  logic                  w_infiniteNext;
  logic [IDX_W-1:0]      w_idxNext;
  logic [CONFIG_ALL-1:0] w_configNext;
  logic                  w_activeNext;
  logic                  w_busyNext;
  logic                  w_doneNext;
  logic                  w_load;
  logic [IDX_W-1:0]      w_loadIdx;

  logic                  w_wrEn;
  logic                  w_endOfPass;

  assign cfg_wr_ready = (r_state == ST_IDLE);
  assign w_wrEn       = cfg_wr_valid && (r_state == ST_IDLE);
  assign w_endOfPass  = r_ctxLast[r_ctxIdx] || (r_ctxIdx == LAST_IDX);

  assign config_all   = r_configAll;
  assign cfg_active   = r_cfgActive;
  assign busy         = r_busy;
  assign done         = r_done;
  assign ctx_idx      = r_ctxIdx;

  // Context store: written only while idle, fully cleared on reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CTX; i++) begin
        r_ctxData[i] <= '0;
        r_ctxHold[i] <= '0;
      end
      r_ctxLast <= '0;
    end else if (w_wrEn) begin
      r_ctxData[cfg_wr_addr] <= cfg_wr_data;
      r_ctxHold[cfg_wr_addr] <= cfg_wr_hold;
      r_ctxLast[cfg_wr_addr] <= cfg_wr_last;
    end
  end

  // Next-state and next-output logic; a context switch loads its slot's data and hold count.
  always_comb begin
    w_stateNext    = r_state;
    w_holdNext     = r_holdCnt;
    w_iterNext     = r_iterCnt;
    w_infiniteNext = r_infinite;
    w_idxNext      = r_ctxIdx;
    w_configNext   = r_configAll;
    w_activeNext   = r_cfgActive;
    w_busyNext     = r_busy;
    w_doneNext     = 1'b0;
    w_load         = 1'b0;
    w_loadIdx      = '0;

    case (r_state)
      ST_IDLE: begin
        w_configNext = '0;
        w_activeNext = 1'b0;
        w_busyNext   = 1'b0;
        w_idxNext    = '0;
        if (start && !stop) begin
          w_stateNext    = ST_RUN;
          w_iterNext     = loop_count;
          w_infiniteNext = (loop_count == '0);
          w_load         = 1'b1;
          w_loadIdx      = '0;
        end
      end
      ST_RUN: begin
        if (stop) begin
          w_stateNext  = ST_IDLE;
          w_configNext = '0;
          w_activeNext = 1'b0;
          w_busyNext   = 1'b0;
          w_idxNext    = '0;
        end else if (r_holdCnt != '0) begin
          w_holdNext = r_holdCnt - CNT_WIDTH'(1);
        end else if (!w_endOfPass) begin
          w_load    = 1'b1;
          w_loadIdx = r_ctxIdx + IDX_W'(1);
        end else if (r_infinite) begin
          w_load    = 1'b1;
          w_loadIdx = '0;
        end else if (r_iterCnt <= CNT_WIDTH'(1)) begin
          w_stateNext  = ST_DONE;
          w_iterNext   = '0;
          w_configNext = '0;
          w_activeNext = 1'b0;
          w_busyNext   = 1'b0;
          w_doneNext   = 1'b1;
          w_idxNext    = '0;
        end else begin
          w_iterNext = r_iterCnt - CNT_WIDTH'(1);
          w_load     = 1'b1;
          w_loadIdx  = '0;
        end
      end
      ST_DONE: begin
        w_stateNext  = ST_IDLE;
        w_configNext = '0;
        w_activeNext = 1'b0;
        w_busyNext   = 1'b0;
        w_idxNext    = '0;
      end
      default: begin
        w_stateNext  = ST_IDLE;
        w_configNext = '0;
        w_activeNext = 1'b0;
        w_busyNext   = 1'b0;
        w_idxNext    = '0;
      end
    endcase

    if (w_load) begin
      w_idxNext    = w_loadIdx;
      w_holdNext   = r_ctxHold[w_loadIdx];
      w_configNext = r_ctxData[w_loadIdx];
      w_activeNext = 1'b1;
      w_busyNext   = 1'b1;
    end
  end

  // State, counters and registered outputs; reset aborts any run without a done pulse.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_holdCnt   <= '0;
      r_iterCnt   <= '0;
      r_infinite  <= 1'b0;
      r_ctxIdx    <= '0;
      r_configAll <= '0;
      r_cfgActive <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_state     <= w_stateNext;
      r_holdCnt   <= w_holdNext;
      r_iterCnt   <= w_iterNext;
      r_infinite  <= w_infiniteNext;
      r_ctxIdx    <= w_idxNext;
      r_configAll <= w_configNext;
      r_cfgActive <= w_activeNext;
      r_busy      <= w_busyNext;
      r_done      <= w_doneNext;
    end
  end

endmodule
